// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the
// fetched-instruction handshake towards decode. The master side is the fetch unit.
interface fetch_pc_unit_if #(
  parameter int Width = 32
);
  logic             imem_req;
  logic [Width-1:0] imem_addr;
  logic             imem_rvalid;
  logic [Width-1:0] imem_rdata;
  logic [Width-1:0] instr;
  logic             instr_valid;
  logic             instr_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata,
    output instr,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata,
    input  instr,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, REQ/WAIT/HOLD/HALT fetch FSM and next-PC select.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned targets set a sticky flag and halt.
module fetch_pc_unit #(
  parameter int               Width       = 32,
  parameter logic [Width-1:0] ResetVector = 32'hBFC0_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        PCsrc,
  input  logic [Width-1:0]  ImmExt,
  input  logic [Width-1:0]  RS1,
  fetch_pc_unit_if.master   bus,
  output logic [Width-1:0]  PC,
  output logic [Width-1:0]  PCPlus4,
  output logic              misalign,
  output logic              halted
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam logic [Width-1:0] Nop = Width'(32'h0000_0013);

  state_t           state_reg, state_next;
  logic [Width-1:0] pc_reg;
  logic [Width-1:0] instr_reg;
  logic             instr_valid_reg;
  logic [Width-1:0] target;
  logic [Width-1:0] next_pc;
  logic             trap;
  logic             take;
  logic             retire;

  assign take    = (state_reg == ST_WAIT) && bus.imem_rvalid;
  assign retire  = (state_reg == ST_HOLD) && bus.instr_ready;
  assign PC      = pc_reg;
  assign PCPlus4 = pc_reg + Width'(4);

  always_comb begin
    target = PCPlus4;
    case (PCsrc)
      2'b00:        target = PCPlus4;
      2'b01, 2'b10: target = pc_reg + ImmExt;
      default:      target = (RS1 + ImmExt) & ~Width'(1);
    endcase
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_reg;

  assign trap    = (target[1:0] != 2'b00);
  assign next_pc = target;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_reg <= 1'b0;
    end else if (retire && trap) begin
      misalign_reg <= 1'b1;
    end
  end

  assign misalign = misalign_reg;
`else
  // Without trapping, low bits are simply dropped so PC stays word aligned.
  assign trap     = 1'b0;
  assign next_pc  = target & ~Width'(3);
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_REQ;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_REQ:  state_next = ST_WAIT;
      ST_WAIT: if (bus.imem_rvalid) state_next = ST_HOLD;
      ST_HOLD: if (bus.instr_ready) state_next = trap ? ST_HALT : ST_REQ;
      default: state_next = ST_HALT;
    endcase
  end

  // Outputs depend on state and PC registers only, never on inputs.
  always_comb begin
    bus.imem_req  = (state_reg == ST_REQ);
    bus.imem_addr = pc_reg;
`ifdef FETCH_MISALIGN_TRAP_EN
    halted        = (state_reg == ST_HALT);
`else
    halted        = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg          <= ResetVector;
      instr_reg       <= Nop;
      instr_valid_reg <= 1'b0;
    end else begin
      if (take) begin
        instr_reg       <= bus.imem_rdata;
        instr_valid_reg <= 1'b1;
      end
      if (retire) begin
        pc_reg          <= next_pc;
        instr_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.instr       = instr_reg;
  assign bus.instr_valid = instr_valid_reg;

endmodule
